// File: rtl/ariane_pkg.sv
// ariane_pkg
// Shared register-file types and helpers for the writeback path.
//   XLEN             : architectural register width
//   REGFILE_NUM_REGS : number of integer registers (x0..x31)
//   REG_ADDR_W       : width of a register index
//   regfile_wb_req_t : one writeback request (destination + data)
//   reg_onehot()     : register index -> one-hot register vector
package ariane_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned REGFILE_NUM_REGS = 32;
  localparam int unsigned REG_ADDR_W       = $clog2(REGFILE_NUM_REGS);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } regfile_wb_req_t;

  function automatic logic [REGFILE_NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [REGFILE_NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ariane_regfile_wb_sel.sv
// ariane_regfile_wb_sel
// Purely combinational writeback grant selection. Requesters are visited in
// rotated order starting at rr_i; x0 writes are accepted without a port,
// writes to a register already granted this cycle are held back, and the
// remaining writes fill ports 0, 1, ... in scan order.
// Ports:
//   rr_i          round-robin start index
//   stall_i       suppress every grant
//   valid_i       per-requester write request
//   waddr_i       per-requester destination register
//   ready_o       per-requester accept
//   port_valid_o  write port k carries a grant
//   port_idx_o    requester index driving write port k
//   any_ready_o   at least one requester accepted (x0 included)
//   last_idx_o    last accepted requester in scan order
module ariane_regfile_wb_sel
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ    = 4,
  parameter int unsigned NR_WPORTS = 2,
  parameter int unsigned PTR_W     = $clog2(NR_REQ)
) (
  input  logic [PTR_W-1:0]                   rr_i,
  input  logic                               stall_i,
  input  logic [NR_REQ-1:0]                  valid_i,
  input  logic [NR_REQ-1:0][REG_ADDR_W-1:0]  waddr_i,
  output logic [NR_REQ-1:0]                  ready_o,
  output logic [NR_WPORTS-1:0]               port_valid_o,
  output logic [NR_WPORTS-1:0][PTR_W-1:0]    port_idx_o,
  output logic                               any_ready_o,
  output logic [PTR_W-1:0]                   last_idx_o
);

  localparam int unsigned IDX_W = PTR_W + 1;

  logic [IDX_W-1:0]            idx_w;
  logic [PTR_W-1:0]            idx;
  logic [REGFILE_NUM_REGS-1:0] taken;
  int unsigned                 used;

  always_comb begin
    ready_o      = '0;
    port_valid_o = '0;
    port_idx_o   = '0;
    any_ready_o  = 1'b0;
    last_idx_o   = '0;
    taken        = '0;
    used         = 0;
    idx_w        = '0;
    idx          = '0;
    if (!stall_i) begin
      for (int unsigned s = 0; s < NR_REQ; s++) begin
        // Rotated position s maps back to requester (rr_i + s) mod NR_REQ.
        idx_w = {1'b0, rr_i} + IDX_W'(s);
        if (idx_w >= IDX_W'(NR_REQ)) idx_w = idx_w - IDX_W'(NR_REQ);
        idx = idx_w[PTR_W-1:0];
        if (valid_i[idx]) begin
          if (waddr_i[idx] == '0) begin
            // x0 is hardwired to zero: accept and drop, no port consumed.
            ready_o[idx] = 1'b1;
            any_ready_o  = 1'b1;
            last_idx_o   = idx;
          end else if (!taken[waddr_i[idx]] && (used < NR_WPORTS)) begin
            // A later same-register write must wait a cycle so writes to one
            // register retire in scan order.
            ready_o[idx] = 1'b1;
            for (int unsigned k = 0; k < NR_WPORTS; k++) begin
              if (k == used) begin
                port_valid_o[k] = 1'b1;
                port_idx_o[k]   = idx;
              end
            end
            taken[waddr_i[idx]] = 1'b1;
            used                = used + 1;
            any_ready_o         = 1'b1;
            last_idx_o          = idx;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ariane_regfile_wb_arbiter.sv
// ariane_regfile_wb_arbiter
// Shares the register-file write ports between NR_REQ writeback requesters.
// Up to NR_WPORTS grants per cycle in round-robin order; grants are
// registered into the write-port bundle one cycle later.
//
// Handshake: a requester holds req_valid_i with req_waddr_i/req_wdata_i; the
// transfer happens in the cycle where req_valid_i and req_ready_o are both 1.
// req_ready_o is combinational from the inputs and rr_q and may be 0 while
// valid is high (port shortage, same-register conflict, stall).
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   stall_i        block all grants this cycle
//   req_valid_i    per-requester write request
//   req_ready_o    per-requester accept (combinational)
//   req_waddr_i    per-requester destination register
//   req_wdata_i    per-requester write data
//   we_o           registered write enable per port
//   waddr_o        registered write address per port
//   wdata_o        registered write data per port
//   pending_o      registers being written by the current we_o/waddr_o
module ariane_regfile_wb_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ     = 4,
  parameter int unsigned NR_WPORTS  = 2,
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                stall_i,
  input  logic [NR_REQ-1:0]                   req_valid_i,
  output logic [NR_REQ-1:0]                   req_ready_o,
  input  logic [NR_REQ-1:0][REG_ADDR_W-1:0]   req_waddr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NR_WPORTS-1:0]                we_o,
  output logic [NR_WPORTS-1:0][REG_ADDR_W-1:0] waddr_o,
  output logic [NR_WPORTS-1:0][DATA_WIDTH-1:0] wdata_o,
  output logic [REGFILE_NUM_REGS-1:0]         pending_o
);

  localparam int unsigned PTR_W = $clog2(NR_REQ);
  localparam int unsigned IDX_W = PTR_W + 1;

  logic [PTR_W-1:0]                       rr_q, rr_d;
  logic [NR_WPORTS-1:0]                   port_valid;
  logic [NR_WPORTS-1:0][PTR_W-1:0]        port_idx;
  logic                                   any_ready;
  logic [PTR_W-1:0]                       last_idx;
  logic [IDX_W-1:0]                       last_inc;

  logic [NR_WPORTS-1:0]                   we_q;
  logic [NR_WPORTS-1:0][REG_ADDR_W-1:0]   waddr_q;
  logic [NR_WPORTS-1:0][DATA_WIDTH-1:0]   wdata_q;

  ariane_regfile_wb_sel #(
    .NR_REQ    (NR_REQ),
    .NR_WPORTS (NR_WPORTS),
    .PTR_W     (PTR_W)
  ) i_sel (
    .rr_i         (rr_q),
    .stall_i      (stall_i),
    .valid_i      (req_valid_i),
    .waddr_i      (req_waddr_i),
    .ready_o      (req_ready_o),
    .port_valid_o (port_valid),
    .port_idx_o   (port_idx),
    .any_ready_o  (any_ready),
    .last_idx_o   (last_idx)
  );

  // Next scan starts just after the last accepted requester, wrapping at NR_REQ.
  always_comb begin
    last_inc = {1'b0, last_idx} + IDX_W'(1);
    rr_d     = rr_q;
    if (any_ready) begin
      rr_d = (last_inc == IDX_W'(NR_REQ)) ? '0 : last_inc[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      we_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rr_q <= rr_d;
      for (int unsigned k = 0; k < NR_WPORTS; k++) begin
        we_q[k] <= port_valid[k];
        // Idle ports keep their last address/data to avoid needless toggling.
        if (port_valid[k]) begin
          waddr_q[k] <= req_waddr_i[port_idx[k]];
          wdata_q[k] <= req_wdata_i[port_idx[k]];
        end
      end
    end
  end

  always_comb begin
    pending_o = '0;
    for (int unsigned k = 0; k < NR_WPORTS; k++) begin
      if (we_q[k]) pending_o = pending_o | reg_onehot(waddr_q[k]);
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule

// File: doc/ariane_regfile_wb_arbiter.md
# ariane_regfile_wb_arbiter

Shares the physical write ports of the FPGA register file between a larger set of writeback requesters (commit ports, CSR/accelerator writeback, debug). Each cycle it grants up to NR_WPORTS requests in round-robin order, never grants two writes to the same register in one cycle, and absorbs x0 writes without consuming a port. Grants are registered into the regfile write-port bundle. It also exports a pending-write vector for the synchronous-read bypass.

## Interface
- NR_REQ, 4, number of writeback requesters (2..8)
- NR_WPORTS, 2, regfile write ports (equals CVA6Cfg.NrCommitPorts; 1..NR_REQ)
- DATA_WIDTH, 32, register data width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- stall_i  in  1  block all grants this cycle
- req_valid_i  in  NR_REQ  requester has a write
- req_ready_o  out  NR_REQ  write accepted this cycle (combinational)
- req_waddr_i  in  NR_REQ×5  destination register
- req_wdata_i  in  NR_REQ×DATA_WIDTH  write data
- we_o  out  NR_WPORTS  regfile write enable (registered)
- waddr_o  out  NR_WPORTS×5  regfile write address (registered)
- wdata_o  out  NR_WPORTS×DATA_WIDTH  regfile write data (registered)
- pending_o  out  32  one-hot OR of waddr_o where we_o set (derived from registered state)

## Operation
- Round-robin pointer rr_q (clog2(NR_REQ) bits). Scan order: rr_q, rr_q+1, … mod NR_REQ.
- Scan rules, applied in order, while stall_i=0:
  - req_valid_i=0: skip.
  - waddr=0: ready=1, no port used, no output write.
  - waddr equals an address already granted this cycle: ready=0 (retried next cycle; preserves order).
  - ports used < NR_WPORTS: ready=1; assigned to port index = number of ports already used.
  - else ready=0.
- stall_i=1: all req_ready_o=0, including x0 requests.
- Output stage: port k loads we=1/waddr/wdata from its assigned grant; unassigned ports load we=0 and keep waddr/wdata unchanged.
- Pointer update: if any ready=1 (x0 included), rr_q <= (index of last requester granted in scan order + 1) mod NR_REQ; otherwise unchanged.
- Requester contract: valid, waddr, wdata stable until ready; arbiter does not depend on this for correctness.

## Timing
- Reset: we_o=0, waddr_o=0, wdata_o=0, pending_o=0, rr_q=0. req_ready_o reflects combinational inputs even in reset; during reset, flops hold reset values and grants are discarded.
- Latency: grant in cycle N -> we_o/waddr_o/wdata_o valid in cycle N+1 -> regfile write at edge ending N+1.
- pending_o valid in N+1, identical cycle to we_o.
- Throughput: NR_WPORTS non-x0 writes per cycle sustained with distinct addresses.
- Same-address pair in one cycle: first in scan order in N, second in N+1 (provided it still wins).
- Reset asserted mid-operation: output writes in flight are dropped (we_o=0 immediately); rr_q returns to 0.
- No combinational path from any input to we_o/waddr_o/wdata_o/pending_o.

## Structure
- Shared package (ariane_pkg): typedef regfile_wb_req_t {waddr[4:0], wdata} parametrised by DATA_WIDTH via CVA6Cfg.XLEN; constant REGFILE_NUM_REGS=32.
- One sub-module: ariane_regfile_wb_sel, purely combinational scan (rotate by rr_q, conflict mask, port-count prefix sum, unrotate) producing ready vector, per-port request index and port-valid, and last-grant index. The top holds rr_q, the output registers and pending_o decode.

## Test plan
- Reset: rst_ni=0 with all valid and stall_i=0 -> we_o=0, pending_o=0, rr_q=0 for the entire reset duration; first grant after release goes to requester 0.
- Fairness: NR_REQ=4, NR_WPORTS=2, all valid with addrs 1,2,3,4 held -> cycle 0 grants {0,1}, cycle 1 grants {2,3}, cycle 2 grants {0,1}; ports carry lower-scan-index on port 0.
- Conflict: req0 and req1 both waddr=5, data 0xA/0xB -> N: ready={1,0}, N+1: we_o[0]=1 waddr 5 data 0xA; N+1: req1 granted, N+2 writes 0xB; final regfile x5=0xB.
- x0 absorb: req0 waddr=0, req1 waddr=7, req2 waddr=8 with rr_q=0 -> all three ready; we_o=2'b11 with addrs 7,8; pending_o=(1<<7)|(1<<8).
- Stall: stall_i=1 for 3 cycles with all valid -> ready=0, we_o=0 one cycle later, rr_q unchanged; grants resume from same pointer.
- Async reset mid-stream: assert rst_ni between clock edges while we_o=2'b11 -> we_o drops to 0 without a clock edge.
